// File: rtl/imem_pkg.sv
// Shared constants for the synchronous instruction memory: fault-bit positions,
// response field widths and the power-up / fault instruction word.
package imem_pkg;

    localparam logic [31:0] NOP_WORD       = 32'h0000_0013;
    localparam int unsigned FAULT_MISALIGN = 0;
    localparam int unsigned FAULT_RANGE    = 1;
    localparam int unsigned FAULT_W        = 2;

    typedef logic [FAULT_W-1:0] fault_t;

    // Packed response layout is {instr, addr, fault}, MSB first.
    function automatic int unsigned resp_width(input int unsigned xlen, input int unsigned aw);
        return xlen + aw + FAULT_W;
    endfunction

endpackage

// File: rtl/imem_resp_fifo.sv
// Two-entry response FIFO; the head entry is held in registers and drives the
// fetch response outputs directly.
module imem_resp_fifo #(
    parameter int unsigned W = 66
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [1:0][W-1:0] ent_q, ent_d;
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              do_push_s, do_pop_s;

    assign full  = (cnt_q == 2'd2);
    assign empty = (cnt_q == 2'd0);
    assign count = cnt_q;
    assign dout  = ent_q[rd_ptr_q];

    // Next-state for storage, pointers and occupancy; flush wins over everything.
    always_comb begin
        ent_d     = ent_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        cnt_d     = cnt_q;
        do_pop_s  = pop && !empty;
        do_push_s = push && (!full || do_pop_s);
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            cnt_d    = 2'd0;
        end else begin
            if (do_push_s) begin
                ent_d[wr_ptr_q] = din;
                wr_ptr_d        = !wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = !rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   cnt_d = cnt_q + 2'd1;
                2'b01:   cnt_d = cnt_q - 2'd1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ent_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            ent_q    <= ent_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_sync_fetch.sv
// Synchronous instruction memory with valid/ready fetch and response channels,
// fault tagging, credit-based request flow control and a byte-enabled load port.
module imem_sync_fetch
    import imem_pkg::*;
#(
    parameter int unsigned      XLEN     = 32,
    parameter int unsigned      DEPTH    = 256,
    parameter int unsigned      AW       = 32,
    parameter logic [XLEN-1:0]  NOP_WORD = imem_pkg::NOP_WORD
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [AW-1:0]       req_addr,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [XLEN-1:0]     resp_instr,
    output logic [AW-1:0]       resp_addr,
    output logic [1:0]          resp_fault,
    input  logic                flush,
    input  logic                prog_we,
    input  logic [AW-1:0]       prog_addr,
    input  logic [XLEN/8-1:0]   prog_be,
    input  logic [XLEN-1:0]     prog_data
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam int unsigned NB = XLEN / 8;
    localparam int unsigned RW = resp_width(XLEN, AW);

    // Words are stored XOR-ed with NOP_WORD so an all-zero power-up RAM reads back as NOP.
    logic [XLEN-1:0] mem_q [DEPTH];

    logic            misalign_s, range_s;
    logic [IW-1:0]   idx_s, prog_idx_s;
    fault_t          fault_s;
    logic            prog_ok_s;
    logic            accept_s, rd_en_s;
    logic [1:0]      outstanding_s;
    logic            push_s, pop_s;
    logic [RW-1:0]   push_data_s, head_s;
    logic [1:0]      fifo_count_s;
    logic            fifo_full_s, fifo_empty_s;
    logic [XLEN-1:0] push_instr_s;

    logic            inflight_q, inflight_d;
    logic [AW-1:0]   if_addr_q, if_addr_d;
    fault_t          if_fault_q, if_fault_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    // Fetch and program address decode.
    always_comb begin
        misalign_s              = (req_addr[1:0] != 2'b00);
        range_s                 = (req_addr[AW-1:2] >= (AW-2)'(DEPTH));
        idx_s                   = req_addr[IW+1:2];
        fault_s                 = '0;
        fault_s[FAULT_MISALIGN] = misalign_s;
        fault_s[FAULT_RANGE]    = range_s;
        prog_idx_s              = prog_addr[IW+1:2];
        prog_ok_s               = prog_we && (prog_addr[1:0] == 2'b00)
                                  && (prog_addr[AW-1:2] < (AW-2)'(DEPTH));
    end

    assign resp_valid    = !fifo_empty_s;
    assign outstanding_s = {1'b0, inflight_q} + fifo_count_s;
    // A pop this cycle frees a slot, which keeps back-to-back fetches at one per cycle.
    assign req_ready     = rst_n && !flush
                           && ((outstanding_s < 2'd2) || (resp_valid && resp_ready));
    assign accept_s      = req_valid && req_ready;
    assign rd_en_s       = accept_s && (fault_s == '0);

    // In-flight read stage next-state and queue handshakes.
    always_comb begin
        inflight_d = accept_s && !flush;
        if (accept_s) begin
            if_addr_d  = req_addr;
            if_fault_d = fault_s;
        end else begin
            if_addr_d  = if_addr_q;
            if_fault_d = if_fault_q;
        end
        if (rd_en_s) begin
            rdata_d = mem_q[idx_s];
        end else begin
            rdata_d = rdata_q;
        end
        if (if_fault_q != '0) begin
            push_instr_s = NOP_WORD;
        end else begin
            push_instr_s = rdata_q ^ NOP_WORD;
        end
        push_s      = inflight_q && !flush;
        pop_s       = resp_valid && resp_ready && !flush;
        push_data_s = {push_instr_s, if_addr_q, if_fault_q};
    end

    // In-flight read stage registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            if_addr_q  <= '0;
            if_fault_q <= '0;
            rdata_q    <= '0;
        end else begin
            inflight_q <= inflight_d;
            if_addr_q  <= if_addr_d;
            if_fault_q <= if_fault_d;
            rdata_q    <= rdata_d;
        end
    end

    // Program port byte writes; the array itself is never reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (prog_ok_s && prog_be[b]) begin
                mem_q[prog_idx_s][b*8 +: 8] <= prog_data[b*8 +: 8] ^ NOP_WORD[b*8 +: 8];
            end
        end
    end

    imem_resp_fifo #(
        .W (RW)
    ) u_resp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s && !fifo_full_s || push_s && pop_s),
        .pop   (pop_s),
        .flush (flush),
        .din   (push_data_s),
        .dout  (head_s),
        .count (fifo_count_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign resp_instr = head_s[RW-1 -: XLEN];
    assign resp_addr  = head_s[FAULT_W +: AW];
    assign resp_fault = head_s[FAULT_W-1:0];

endmodule

// File: tb/tb_imem_sync_fetch.sv
// Self-checking bench for imem_sync_fetch: directed scenarios plus a randomized
// phase checked against a queue-based transaction model.
module tb_imem_sync_fetch;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned AW    = 32;
    localparam int unsigned NB    = XLEN / 8;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            req_valid, req_ready;
    logic [AW-1:0]   req_addr;
    logic            resp_valid, resp_ready;
    logic [XLEN-1:0] resp_instr;
    logic [AW-1:0]   resp_addr;
    logic [1:0]      resp_fault;
    logic            flush;
    logic            prog_we;
    logic [AW-1:0]   prog_addr;
    logic [NB-1:0]   prog_be;
    logic [XLEN-1:0] prog_data;

    int errors = 0;
    int checks = 0;
    int unsigned cyc = 0;

    logic [31:0] model_mem [DEPTH];

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic [1:0]  fault;
        int unsigned vis;
    } exp_t;
    exp_t expq[$];

    imem_sync_fetch #(
        .XLEN(XLEN), .DEPTH(DEPTH), .AW(AW), .NOP_WORD(NOP)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_instr(resp_instr), .resp_addr(resp_addr), .resp_fault(resp_fault),
        .flush(flush),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_be(prog_be), .prog_data(prog_data)
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] model_fault(input logic [31:0] a);
        logic oor, mis;
        oor = (a / 32'd4) >= DEPTH;
        mis = (a % 32'd4) != 32'd0;
        return {oor, mis};
    endfunction

    function automatic logic [31:0] model_word(input logic [31:0] a);
        if (model_fault(a) != 2'b00) return NOP;
        else return model_mem[8'(a / 32'd4)];
    endfunction

    // One clock: applies the program write to the model after the edge (read-first).
    task automatic tick();
        logic        do_wr;
        logic [7:0]  wi;
        logic [31:0] nw;
        do_wr = prog_we && (prog_addr % 32'd4 == 32'd0) && (prog_addr / 32'd4 < DEPTH);
        wi = 8'd0;
        nw = 32'd0;
        if (do_wr) begin
            wi = 8'(prog_addr / 32'd4);
            nw = model_mem[wi];
            for (int b = 0; b < NB; b++) begin
                if (prog_be[b]) nw[b*8 +: 8] = prog_data[b*8 +: 8];
            end
        end
        @(posedge clk);
        #1;
        if (do_wr) model_mem[wi] = nw;
        cyc++;
    endtask

    task automatic idle();
        req_valid = 1'b0; req_addr = 32'h0; resp_ready = 1'b1; flush = 1'b0;
        prog_we = 1'b0; prog_addr = 32'h0; prog_be = 4'h0; prog_data = 32'h0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        repeat (3) tick();
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b expected 0", req_ready); end
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (resp_instr !== 32'h0) begin errors++; $display("FAIL reset_resp_instr: got %h expected 0", resp_instr); end
        checks++; if (resp_addr !== 32'h0) begin errors++; $display("FAIL reset_resp_addr: got %h expected 0", resp_addr); end
        checks++; if (resp_fault !== 2'b00) begin errors++; $display("FAIL reset_resp_fault: got %b expected 00", resp_fault); end
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", req_ready); end
        tick();
    endtask

    task automatic test_fetch_nop();
        req_valid = 1'b1; req_addr = 32'h0; resp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL nop_ready: got %b expected 1", req_ready); end
        tick();
        req_valid = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL nop_early_valid: got %b expected 0", resp_valid); end
        tick();
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL nop_valid: got %b expected 1", resp_valid); end
        checks++; if (resp_instr !== NOP) begin errors++; $display("FAIL nop_instr: got %h expected %h", resp_instr, NOP); end
        checks++; if (resp_addr !== 32'h0) begin errors++; $display("FAIL nop_addr: got %h expected 0", resp_addr); end
        checks++; if (resp_fault !== 2'b00) begin errors++; $display("FAIL nop_fault: got %b expected 00", resp_fault); end
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL nop_drained: got %b expected 0", resp_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ea [3];
        logic [31:0] ew [3];
        ea = '{32'h4, 32'h8, 32'hC};
        ew = '{32'h0010_0093, NOP, NOP};
        prog_we = 1'b1; prog_addr = 32'h4; prog_be = 4'hF; prog_data = 32'h0010_0093;
        tick();
        prog_we = 1'b0;
        for (int i = 0; i < 6; i++) begin
            resp_ready = 1'b1;
            if (i < 3) begin req_valid = 1'b1; req_addr = ea[i]; end
            else begin req_valid = 1'b0; end
            #1;
            if (i < 3) begin
                checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: got %b expected 1", i, req_ready); end
            end
            if (i >= 2 && i < 5) begin
                checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b expected 1", i, resp_valid); end
                checks++; if (resp_instr !== ew[i-2]) begin errors++; $display("FAIL b2b_instr[%0d]: got %h expected %h", i, resp_instr, ew[i-2]); end
                checks++; if (resp_addr !== ea[i-2]) begin errors++; $display("FAIL b2b_addr[%0d]: got %h expected %h", i, resp_addr, ea[i-2]); end
            end else begin
                checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle[%0d]: got %b expected 0", i, resp_valid); end
            end
            tick();
        end
    endtask

    task automatic test_faults();
        logic [31:0] fa [5];
        logic [1:0]  ff [5];
        fa = '{32'h6, 32'h400, 32'h3FC, 32'h403, 32'h8000_0004};
        ff = '{2'b01, 2'b10, 2'b00, 2'b11, 2'b10};
        for (int i = 0; i < 8; i++) begin
            resp_ready = 1'b1;
            if (i < 5) begin req_valid = 1'b1; req_addr = fa[i]; end
            else begin req_valid = 1'b0; end
            #1;
            if (i >= 2 && i < 7) begin
                checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL fault_valid[%0d]: got %b expected 1", i, resp_valid); end
                checks++; if (resp_fault !== ff[i-2]) begin errors++; $display("FAIL fault_bits[%0d]: got %b expected %b", i, resp_fault, ff[i-2]); end
                checks++; if (resp_instr !== NOP) begin errors++; $display("FAIL fault_instr[%0d]: got %h expected %h", i, resp_instr, NOP); end
                checks++; if (resp_addr !== fa[i-2]) begin errors++; $display("FAIL fault_addr[%0d]: got %h expected %h", i, resp_addr, fa[i-2]); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h4;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0: got %b expected 1", req_ready); end
        tick();
        req_addr = 32'h8;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b expected 1", req_ready); end
        tick();
        req_addr = 32'hC;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_ready[%0d]: got %b expected 0", i, req_ready); end
            checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL bp_stall_valid[%0d]: got %b expected 1", i, resp_valid); end
            checks++; if (resp_addr !== 32'h4) begin errors++; $display("FAIL bp_stall_addr[%0d]: got %h expected 4", i, resp_addr); end
            checks++; if (resp_instr !== 32'h0010_0093) begin errors++; $display("FAIL bp_stall_instr[%0d]: got %h expected 00100093", i, resp_instr); end
            tick();
        end
        resp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_pop_ready: got %b expected 1", req_ready); end
        tick();
        req_valid = 1'b0;
        #1;
        checks++; if (resp_addr !== 32'h8 || resp_valid !== 1'b1) begin errors++; $display("FAIL bp_second: got %h/%b expected 8/1", resp_addr, resp_valid); end
        tick();
        checks++; if (resp_addr !== 32'hC || resp_valid !== 1'b1) begin errors++; $display("FAIL bp_third: got %h/%b expected c/1", resp_addr, resp_valid); end
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", resp_valid); end
    endtask

    task automatic test_flush();
        resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h8;
        tick();
        req_addr = 32'hC;
        tick();
        req_valid = 1'b0;
        tick();
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h4; resp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_ready: got %b expected 0", req_ready); end
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL flush_pre_valid: got %b expected 1", resp_valid); end
        tick();
        flush = 1'b0; req_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_cleared[%0d]: got %b expected 0", i, resp_valid); end
            tick();
        end
        req_valid = 1'b1; req_addr = 32'h4;
        tick();
        req_valid = 1'b0;
        tick();
        checks++; if (resp_valid !== 1'b1 || resp_addr !== 32'h4) begin errors++; $display("FAIL flush_refetch: got %b/%h expected 1/4", resp_valid, resp_addr); end
        checks++; if (resp_instr !== 32'h0010_0093) begin errors++; $display("FAIL flush_refetch_instr: got %h expected 00100093", resp_instr); end
        tick();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_single: got %b expected 0", resp_valid); end
    endtask

    task automatic test_prog_collision();
        resp_ready = 1'b1;
        prog_we = 1'b1; prog_addr = 32'h8; prog_be = 4'b0011; prog_data = 32'hAABB_CCDD;
        req_valid = 1'b1; req_addr = 32'h8;
        tick();
        prog_we = 1'b0;
        tick();
        req_valid = 1'b0;
        #1;
        checks++; if (resp_instr !== NOP || resp_addr !== 32'h8) begin errors++; $display("FAIL prog_read_first: got %h@%h expected %h@8", resp_instr, resp_addr, NOP); end
        tick();
        checks++; if (resp_instr !== 32'h0000_CCDD) begin errors++; $display("FAIL prog_new_data: got %h expected 0000ccdd", resp_instr); end
        tick();
        prog_we = 1'b1; prog_addr = 32'hA; prog_be = 4'hF; prog_data = 32'h1111_1111;
        tick();
        prog_addr = 32'h408; prog_data = 32'h2222_2222;
        tick();
        prog_we = 1'b0; req_valid = 1'b1; req_addr = 32'h8;
        tick();
        req_valid = 1'b0;
        tick();
        checks++; if (resp_instr !== 32'h0000_CCDD) begin errors++; $display("FAIL prog_ignored_writes: got %h expected 0000ccdd", resp_instr); end
        tick();
    endtask

    task automatic test_random();
        logic ev, er;
        exp_t e;
        int unsigned r;
        expq.delete();
        for (int i = 0; i < 500; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            if (r == 0) req_addr = $urandom;
            else if (r == 1) req_addr = $urandom_range(0, 1100);
            else req_addr = $urandom_range(0, 15) << 2;
            resp_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 24) == 0);
            prog_we = ($urandom_range(0, 5) == 0);
            prog_addr = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 1100) : ($urandom_range(0, 15) << 2);
            prog_be = 4'($urandom_range(0, 15));
            prog_data = $urandom;
            #1;
            ev = (expq.size() > 0) && (expq[0].vis <= cyc);
            er = !flush && ((expq.size() < 2) || (ev && resp_ready));
            checks++; if (resp_valid !== ev) begin errors++; $display("FAIL rnd_valid@%0d: got %b expected %b", cyc, resp_valid, ev); end
            checks++; if (req_ready !== er) begin errors++; $display("FAIL rnd_ready@%0d: got %b expected %b", cyc, req_ready, er); end
            if (ev) begin
                checks++;
                if (resp_instr !== expq[0].instr || resp_addr !== expq[0].addr || resp_fault !== expq[0].fault) begin
                    errors++;
                    $display("FAIL rnd_data@%0d: got %h@%h/%b expected %h@%h/%b", cyc, resp_instr, resp_addr, resp_fault,
                             expq[0].instr, expq[0].addr, expq[0].fault);
                end
            end
            if (flush) begin
                expq.delete();
            end else begin
                if (ev && resp_ready) void'(expq.pop_front());
                if (req_valid && er) begin
                    e.instr = model_word(req_addr);
                    e.addr  = req_addr;
                    e.fault = model_fault(req_addr);
                    e.vis   = cyc + 2;
                    expq.push_back(e);
                end
            end
            tick();
        end
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        expq.delete();
    endtask

    task automatic test_reset_midstream();
        resp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h4;
        tick();
        req_addr = 32'h8;
        tick();
        req_valid = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_pre: got %b expected 1", resp_valid); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0", resp_valid); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ready: got %b expected 0", req_ready); end
        checks++; if (resp_instr !== 32'h0) begin errors++; $display("FAIL rst_mid_instr: got %h expected 0", resp_instr); end
        tick();
        rst_n = 1'b1; resp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_release: got %b expected 1", req_ready); end
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_dropped[%0d]: got %b expected 0", i, resp_valid); end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = NOP;
        test_reset();
        test_fetch_nop();
        test_back_to_back();
        test_faults();
        test_backpressure();
        test_flush();
        test_prog_collision();
        test_random();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
